// File: rtl/mem_bus_arbiter_if.sv
// Master-to-memory request/acknowledge bus shared by the D-side, I-side and memory ports.
// Read data travels outside this bus, directly from memory to both masters.
interface mem_bus_arbiter_if;
    logic [31:0] ADDR;
    logic [1:0]  BURST;
    logic        REQ;
    logic        WRB;
    logic [31:0] WDATA;
    logic [3:0]  BSTROBE;
    logic        ACK;
    logic        STALL;

    modport master (
        output ADDR,
        output BURST,
        output REQ,
        output WRB,
        output WDATA,
        output BSTROBE,
        input  ACK,
        input  STALL
    );

    modport slave (
        input  ADDR,
        input  BURST,
        input  REQ,
        input  WRB,
        input  WDATA,
        input  BSTROBE,
        output ACK,
        output STALL
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (data over instruction) burst arbiter in front of one memory port.
// Define ARB_STARVE_GUARD_EN to let a waiting I-side win after STARVE_LIMIT D grants.
module mem_bus_arbiter #(
    parameter int BURST_LEN    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              proc_clk,
    input  logic              proc_rst_n,
    mem_bus_arbiter_if.slave  d,
    mem_bus_arbiter_if.slave  i,
    mem_bus_arbiter_if.master m
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] beat;
    logic          armed;
    logic          d_last;
    logic          i_last;
    logic          i_first;
    logic          grant_d;
    logic          grant_i;

    // Burst types 00 and 11 both complete on their first beat.
    assign d_last = (d.BURST == 2'b00) || (d.BURST == 2'b11) ||
                    (beat == LAST_BEAT);
    assign i_last = (i.BURST == 2'b00) || (i.BURST == 2'b11) ||
                    (beat == LAST_BEAT);

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve;

    assign i_first = i.REQ && (starve >= STARVE_MAX);

    always_ff @(posedge proc_clk or negedge proc_rst_n) begin
        if (!proc_rst_n) begin
            starve <= '0;
        end else if (grant_d && i.REQ && (starve < STARVE_MAX)) begin
            starve <= starve + SW'(1);
        end else if (grant_i) begin
            starve <= '0;
        end
    end
`else
    assign i_first = 1'b0;
`endif

    // armed holds off grants until the second edge after reset release.
    assign grant_d = armed && (state == IDLE) && d.REQ && !i_first;
    assign grant_i = armed && (state == IDLE) && i.REQ && !grant_d;

    always_ff @(posedge proc_clk or negedge proc_rst_n) begin
        if (!proc_rst_n) begin
            state <= IDLE;
            beat  <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    beat <= '0;
                    if (grant_d) begin
                        state <= GNT_D;
                    end else if (grant_i) begin
                        state <= GNT_I;
                    end
                end
                GNT_D: begin
                    if (!d.REQ) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else if (m.ACK) begin
                        if (d_last) begin
                            state <= IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + CW'(1);
                        end
                    end
                end
                GNT_I: begin
                    if (!i.REQ) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else if (m.ACK) begin
                        if (i_last) begin
                            state <= IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        m.ADDR    = '0;
        m.BURST   = '0;
        m.REQ     = 1'b0;
        m.WRB     = 1'b0;
        m.WDATA   = '0;
        m.BSTROBE = '0;
        d.ACK     = 1'b0;
        d.STALL   = d.REQ;
        i.ACK     = 1'b0;
        i.STALL   = i.REQ;
        unique case (state)
            GNT_D: begin
                m.ADDR    = d.ADDR;
                m.BURST   = d.BURST;
                m.REQ     = d.REQ;
                m.WRB     = d.WRB;
                m.WDATA   = d.WDATA;
                m.BSTROBE = d.BSTROBE;
                d.ACK     = m.ACK;
                d.STALL   = m.STALL;
            end
            GNT_I: begin
                m.ADDR    = i.ADDR;
                m.BURST   = i.BURST;
                m.REQ     = i.REQ;
                i.ACK     = m.ACK;
                i.STALL   = m.STALL;
            end
            default: begin
            end
        endcase
    end

    // The I-side is read-only; its write fields are never forwarded.
    logic unused_i_write;
    assign unused_i_write = ^{i.WRB, i.WDATA, i.BSTROBE};

endmodule
